// File: rtl/fetch_pc_unit.sv
// Fetch front end: owns the fetch PC, picks the next PC and fills IF/ID.
// Also counts resolved branches and mispredictions (saturating).
module fetch_pc_unit #(
    parameter int unsigned              DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0]    RESET_PC   = '0,
    parameter int unsigned              CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic [DATA_WIDTH-1:0] instr_F,
    input  logic                  pred_taken,
    input  logic [DATA_WIDTH-1:0] pred_target,
    input  logic                  res_valid,
    input  logic                  res_taken,
    input  logic [DATA_WIDTH-1:0] res_target,
    input  logic                  res_correct,
    input  logic                  pred_error,
    input  logic [DATA_WIDTH-1:0] fix_target,
    output logic [DATA_WIDTH-1:0] pc_F,
    output logic [DATA_WIDTH-1:0] pc_D,
    output logic [DATA_WIDTH-1:0] instr_D,
    output logic                  pred_D,
    output logic                  valid_D,
    output logic                  flush_D,
    output logic [CNT_WIDTH-1:0]  cnt_branch,
    output logic [CNT_WIDTH-1:0]  cnt_mispred
);

    localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h13);

    typedef enum logic {
        S_RUN,
        S_REDIRECT
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [DATA_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0] r_pc_d;
    logic [DATA_WIDTH-1:0] r_instr_d;
    logic                  r_pred_d;
    logic                  r_valid_d;
    logic [CNT_WIDTH-1:0]  r_cnt_br;
    logic [CNT_WIDTH-1:0]  r_cnt_mis;

    logic [DATA_WIDTH-1:0] w_pc_nxt;
    logic [DATA_WIDTH-1:0] w_fix_al;
    logic [DATA_WIDTH-1:0] w_res_al;
    logic [DATA_WIDTH-1:0] w_pred_al;
    logic                  w_res_fix;
    logic                  w_flush;
    logic                  w_pred_en;
    logic                  w_mis_evt;

    assign w_fix_al  = {fix_target[DATA_WIDTH-1:2], 2'b00};
    assign w_res_al  = {res_target[DATA_WIDTH-1:2], 2'b00};
    assign w_pred_al = {pred_target[DATA_WIDTH-1:2], 2'b00};

    assign w_res_fix = res_valid & res_taken & ~res_correct;
    assign w_flush   = pred_error | w_res_fix;
    assign w_mis_evt = pred_error | (res_taken & ~res_correct);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A stalled redirect slot keeps suppressing the prediction until it fetches.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_RUN: begin
                if (w_flush) w_state_nxt = S_REDIRECT;
            end
            S_REDIRECT: begin
                if (!w_flush && !stall) w_state_nxt = S_RUN;
            end
        endcase
    end

    always_comb begin
        w_pred_en = (r_state == S_RUN);
    end

    always_comb begin
        w_pc_nxt = r_pc + DATA_WIDTH'(4);
        if (pred_error) begin
            w_pc_nxt = w_fix_al;
        end else if (w_res_fix) begin
            w_pc_nxt = w_res_al;
        end else if (stall) begin
            w_pc_nxt = r_pc;
        end else if (pred_taken && w_pred_en) begin
            w_pc_nxt = w_pred_al;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_flush) begin
            r_pc_d    <= '0;
            r_instr_d <= NOP;
            r_pred_d  <= 1'b0;
            r_valid_d <= 1'b0;
        end else if (!stall) begin
            r_pc_d    <= r_pc;
            r_instr_d <= instr_F;
            r_pred_d  <= pred_taken;
            r_valid_d <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_br  <= '0;
            r_cnt_mis <= '0;
        end else if (res_valid) begin
            if (r_cnt_br != '1) r_cnt_br <= r_cnt_br + 1'b1;
            if (w_mis_evt && r_cnt_mis != '1) begin
                r_cnt_mis <= r_cnt_mis + 1'b1;
            end
        end
    end

    assign pc_F        = r_pc;
    assign pc_D        = r_pc_d;
    assign instr_D     = r_instr_d;
    assign pred_D      = r_pred_d;
    assign valid_D     = r_valid_d;
    assign flush_D     = w_flush;
    assign cnt_branch  = r_cnt_br;
    assign cnt_mispred = r_cnt_mis;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed test-plan steps plus random traffic
// checked against a priority-list reference model.
module tb_fetch_pc_unit;

    localparam int          CW  = 4;
    localparam logic [31:0] RPC = 32'h100;
    localparam logic [31:0] NOP = 32'h13;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic [31:0] instr_F = '0;
    logic        pred_taken = 1'b0;
    logic [31:0] pred_target = '0;
    logic        res_valid = 1'b0;
    logic        res_taken = 1'b0;
    logic [31:0] res_target = '0;
    logic        res_correct = 1'b0;
    logic        pred_error = 1'b0;
    logic [31:0] fix_target = '0;
    logic [31:0] pc_F, pc_D, instr_D;
    logic        pred_D, valid_D, flush_D;
    logic [CW-1:0] cnt_branch, cnt_mispred;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_pc, m_pcD, m_instrD;
    bit          m_predD, m_validD, m_redir;
    int          m_br, m_mis;

    fetch_pc_unit #(
        .DATA_WIDTH(32),
        .RESET_PC(RPC),
        .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall), .instr_F(instr_F),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .res_valid(res_valid), .res_taken(res_taken),
        .res_target(res_target), .res_correct(res_correct),
        .pred_error(pred_error), .fix_target(fix_target),
        .pc_F(pc_F), .pc_D(pc_D), .instr_D(instr_D), .pred_D(pred_D),
        .valid_D(valid_D), .flush_D(flush_D),
        .cnt_branch(cnt_branch), .cnt_mispred(cnt_mispred)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        stall = 0; pred_taken = 0; pred_target = '0;
        res_valid = 0; res_taken = 0; res_target = '0; res_correct = 0;
        pred_error = 0; fix_target = '0; instr_F = $urandom;
    endtask

    // One clock: model predicts from the spec rules, then DUT is compared.
    task automatic step();
        bit fl, mis;
        logic [31:0] npc;
        #1;
        fl  = pred_error || (res_valid && res_taken && !res_correct);
        mis = pred_error || (res_taken && !res_correct);
        if (!rst) check("flush_D", 32'(flush_D), 32'(fl));
        if (rst) begin
            m_pc = RPC; m_pcD = 0; m_instrD = NOP;
            m_predD = 0; m_validD = 0; m_redir = 0; m_br = 0; m_mis = 0;
        end else begin
            if (pred_error) npc = fix_target & ~32'h3;
            else if (fl) npc = res_target & ~32'h3;
            else if (stall) npc = m_pc;
            else if (pred_taken && !m_redir) npc = pred_target & ~32'h3;
            else npc = m_pc + 32'd4;
            if (fl) begin
                m_pcD = 0; m_instrD = NOP; m_predD = 0; m_validD = 0;
            end else if (!stall) begin
                m_pcD = m_pc; m_instrD = instr_F;
                m_predD = pred_taken; m_validD = 1;
            end
            if (res_valid) begin
                m_br = (m_br + 1 > 15) ? 15 : m_br + 1;
                if (mis) m_mis = (m_mis + 1 > 15) ? 15 : m_mis + 1;
            end
            m_redir = fl ? 1'b1 : (m_redir && stall);
            m_pc = npc;
        end
        @(posedge clk);
        #1;
        check("pc_F", pc_F, m_pc);
        check("pc_D", pc_D, m_pcD);
        check("instr_D", instr_D, m_instrD);
        check("pred_D", 32'(pred_D), 32'(m_predD));
        check("valid_D", 32'(valid_D), 32'(m_validD));
        check("cnt_branch", 32'(cnt_branch), 32'(m_br));
        check("cnt_mispred", 32'(cnt_mispred), 32'(m_mis));
    endtask

    task automatic redirect_to(input logic [31:0] t);
        idle();
        res_valid = 1; res_taken = 1; res_correct = 0; res_target = t;
        step();
        idle();
    endtask

    initial begin
        int prev_mis;
        idle();
        rst = 1;
        step();
        step();
        check("rst_pc_F", pc_F, 32'h100);
        check("rst_instr_D", instr_D, NOP);
        check("rst_valid_D", 32'(valid_D), 32'd0);
        check("rst_cnt", 32'(cnt_branch), 32'd0);
        rst = 0;
        #1;
        check("rel_valid0", 32'(valid_D), 32'd0);
        step();
        check("seq_104", pc_F, 32'h104);
        check("rel_valid1", 32'(valid_D), 32'd1);
        step();
        check("seq_108", pc_F, 32'h108);

        redirect_to(32'h1C);
        step();
        check("at_20", pc_F, 32'h20);
        pred_taken = 1; pred_target = 32'h83;
        step();
        check("pred_pc", pc_F, 32'h80);
        check("pred_pcD", pc_D, 32'h20);
        check("pred_D1", 32'(pred_D), 32'd1);

        idle();
        prev_mis = m_mis;
        pred_error = 1; fix_target = 32'h44; pred_taken = 1;
        pred_target = 32'h300; res_valid = 1;
        #1;
        check("perr_flush", 32'(flush_D), 32'd1);
        step();
        check("perr_pc", pc_F, 32'h44);
        check("perr_nop", instr_D, NOP);
        check("perr_valid", 32'(valid_D), 32'd0);
        check("perr_cnt", 32'(cnt_mispred), 32'(prev_mis + 1));
        idle();
        pred_taken = 1; pred_target = 32'h300;
        step();
        check("redir_seq", pc_F, 32'h48);

        idle();
        stall = 1; res_valid = 1; res_taken = 1; res_target = 32'h200;
        step();
        check("stall_redir_pc", pc_F, 32'h200);
        check("stall_redir_valid", 32'(valid_D), 32'd0);
        idle();
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_pc", pc_F, 32'h200);
            check("hold_instr", instr_D, NOP);
        end
        idle();

        redirect_to(32'hFFFF_FFFC);
        step();
        check("wrap", pc_F, 32'h0);

        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 39) == 0);
            stall = ($urandom_range(0, 3) == 0);
            instr_F = $urandom;
            pred_taken = ($urandom_range(0, 2) == 0);
            pred_target = $urandom;
            res_valid = ($urandom_range(0, 2) == 0);
            res_taken = 1'($urandom);
            res_correct = 1'($urandom);
            res_target = $urandom;
            pred_error = res_valid && !res_taken && ($urandom_range(0, 3) == 0);
            fix_target = $urandom;
            step();
        end

        idle();
        rst = 1;
        step();
        rst = 0;
        for (int i = 0; i < 20; i++) begin
            res_valid = 1; res_taken = 1; res_correct = 0;
            res_target = 32'h400;
            step();
        end
        check("sat_branch", 32'(cnt_branch), 32'hF);
        check("sat_mispred", 32'(cnt_mispred), 32'hF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Instruction-fetch front end for the 5-stage RISC-V pipeline. It owns the fetch PC register, selects the next PC from sequential, predicted, resolved and corrected targets, and drives the IF/ID pipeline register. It sits directly upstream of the branch predictor: it supplies the predictor's current `pc` and consumes its `prediction`/`label` outputs and its MEM-stage `error`/`new_label` correction. It also keeps saturating branch-performance counters.

## Interface
- `DATA_WIDTH`, 32, PC and instruction width
- `RESET_PC`, 32'h0000_0000, fetch address after reset
- `CNT_WIDTH`, 16, width of each performance counter
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `stall`  in  1  load-use hold: freeze PC and IF/ID
- `instr_F`  in  DATA_WIDTH  instruction memory data for `pc_F`, same cycle
- `pred_taken`  in  1  predictor `prediction` for `pc_F`
- `pred_target`  in  DATA_WIDTH  predictor `label` for `pc_F`
- `res_valid`  in  1  a jump/branch is in MEM this cycle
- `res_taken`  in  1  resolved outcome (`pcsrc`)
- `res_target`  in  DATA_WIDTH  resolved taken target
- `res_correct`  in  1  predictor `correct`
- `pred_error`  in  1  predictor `error` (predicted taken, actually not taken)
- `fix_target`  in  DATA_WIDTH  predictor `new_label` (pc_M+4)
- `pc_F`  out  DATA_WIDTH  current fetch PC, to imem and predictor
- `pc_D`  out  DATA_WIDTH  IF/ID PC
- `instr_D`  out  DATA_WIDTH  IF/ID instruction
- `pred_D`  out  1  IF/ID prediction bit
- `valid_D`  out  1  IF/ID slot holds a real instruction
- `flush_D`  out  1  combinational: IF/ID and younger stages must squash this cycle
- `cnt_branch`  out  CNT_WIDTH  resolved branches
- `cnt_mispred`  out  CNT_WIDTH  mispredictions

## Operation
- Next-PC priority, highest first:
  1. `rst` → `RESET_PC`
  2. `pred_error` → `fix_target`
  3. `res_valid & res_taken & ~res_correct` → `res_target`
  4. `stall` → hold `pc_F`
  5. `pred_taken` → `pred_target`
  6. otherwise → `pc_F + 4`
- `flush_D` = case 2 or 3, independent of `stall`.
- All targets have bits [1:0] forced to 0 before loading.
- `pc_F + 4` wraps modulo 2^DATA_WIDTH; no overflow flag.
- IF/ID register:
  - On `rst` or `flush_D`: `valid_D=0`, `instr_D=32'h0000_0013` (NOP), `pc_D=0`, `pred_D=0`.
  - Else on `stall`: all IF/ID fields hold.
  - Else: load `pc_F`, `instr_F`, `pred_taken`, and `valid_D=1`.
- Counters, active only when `res_valid=1`:
  - `cnt_branch` increments.
  - `cnt_mispred` increments when `pred_error | (res_taken & ~res_correct)`.
  - Both saturate at all-ones.
  - Both reset to 0.
- Control is a two-state FSM:
  - States: RUN and REDIRECT.
  - RUN → REDIRECT on `flush_D`. REDIRECT → RUN after one cycle.
  - In REDIRECT, `pred_taken` is ignored (the slot following a correction fetches sequentially). `pred_error`/redirect still take priority.
  - REDIRECT with `stall=1` remains in REDIRECT.
  - Reset state is RUN.

## Timing
- All state updates on the rising edge of `clk`. `flush_D` is the only combinational output.
- Reset values: `pc_F=RESET_PC`, `pc_D=0`, `instr_D=NOP`, `pred_D=0`, `valid_D=0`, counters 0, FSM in RUN.
- Fetch latency: the instruction at `pc_F` appears on `instr_D` one cycle later.
- Redirect penalty: a MEM-stage correction loads the new `pc_F` next edge. Squashing of the three younger slots (IF/ID here, ID/EX and EX/MEM in their own registers) is driven by `flush_D` in the same cycle.
- `rst` asserted mid-redirect overrides all other inputs in that cycle.
- Simultaneous `pred_error` and `res_taken` is illegal per the predictor contract. If it occurs, `pred_error` wins.

## Test plan
- Reset: hold `rst` 2 cycles with `RESET_PC=32'h100`, then release with no branches → `pc_F` sequence 0x100, 0x104, 0x108. `valid_D=0` on the first cycle after release, then 1.
- Predicted taken: at `pc_F=0x20`, drive `pred_taken=1`, `pred_target=0x83` → next `pc_F=0x80`. `pred_D=1` with `pc_D=0x20`.
- Predict-taken error: `pred_error=1`, `fix_target=0x44`, `pred_taken=1` the same cycle → `pc_F=0x44`, `flush_D=1`, next `instr_D=0x13`, `valid_D=0`, `cnt_mispred` +1. The following fetch ignores `pred_taken`.
- Stall vs redirect: `stall=1` with `res_valid=res_taken=1`, `res_correct=0`, `res_target=0x200` → `pc_F=0x200` and IF/ID flushed. With `stall=1` alone, `pc_F` and IF/ID hold 3 cycles unchanged.
- Wrap: `pc_F=32'hFFFF_FFFC`, no branch → next `pc_F=0`.
- Counter saturation: with `CNT_WIDTH=4`, 20 resolved mispredicts → `cnt_branch=cnt_mispred=4'hF`.
